// File: rtl/id_ex_alu_stage.sv
// ID/EX pipeline register with integrated ALU-control decode.
// Captures operands, destination and write-back enable from decode, and
// translates ALUOp/funct7/funct3 into a 4-bit ALU operation code one clock later.
// Flush inserts a bubble, stall freezes the stage, and reset clears it.
module id_ex_alu_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   input  logic [1:0]       ALUOp_i,
   input  logic [6:0]       funct7_i,
   input  logic [2:0]       funct3_i,
   input  logic             ALUSrc_i,
   input  logic [WIDTH-1:0] RS1data_i,
   input  logic [WIDTH-1:0] RS2data_i,
   input  logic [WIDTH-1:0] imm_i,
   input  logic [4:0]       RDaddr_i,
   input  logic             RegWrite_i,
   input  logic             stall_i,
   input  logic             flush_i,
   output logic [WIDTH-1:0] data1_o,
   output logic [WIDTH-1:0] data2_o,
   output logic [3:0]       ALUCtrl_o,
   output logic [4:0]       RDaddr_o,
   output logic             RegWrite_o,
   output logic             valid_o,
   output logic             illegal_o
);

   localparam logic [3:0] CTRL_AND = 4'b0000;
   localparam logic [3:0] CTRL_XOR = 4'b0001;
   localparam logic [3:0] CTRL_ADD = 4'b0010;
   localparam logic [3:0] CTRL_SUB = 4'b0110;
   localparam logic [3:0] CTRL_SLL = 4'b1000;
   localparam logic [3:0] CTRL_MUL = 4'b1001;
   localparam logic [3:0] CTRL_SRA = 4'b1010;
   localparam logic [3:0] CTRL_ILL = 4'b1111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MULD = 7'b0000001;

   logic [WIDTH-1:0] data1_reg, data1_next;
   logic [WIDTH-1:0] data2_reg, data2_next;
   logic [3:0]       ctrl_reg, ctrl_next;
   logic [4:0]       rd_reg, rd_next;
   logic             regwrite_reg, regwrite_next;
   logic             valid_reg, valid_next;
   logic             illegal_reg, illegal_next;

   logic [3:0]       dec_ctrl;
   logic             dec_illegal;

   // Translate the op class and function fields into an ALU code; unknown encodings flag illegal.
   always_comb begin
      dec_ctrl    = CTRL_ILL;
      dec_illegal = 1'b1;
      case (ALUOp_i)
         2'b00: begin
            dec_ctrl    = CTRL_ADD;
            dec_illegal = 1'b0;
         end
         2'b01: begin
            dec_ctrl    = CTRL_SUB;
            dec_illegal = 1'b0;
         end
         2'b10: begin
            dec_illegal = 1'b0;
            case ({funct7_i, funct3_i})
               {F7_BASE, 3'b000}: dec_ctrl = CTRL_ADD;
               {F7_ALT,  3'b000}: dec_ctrl = CTRL_SUB;
               {F7_MULD, 3'b000}: dec_ctrl = CTRL_MUL;
               {F7_BASE, 3'b111}: dec_ctrl = CTRL_AND;
               {F7_BASE, 3'b100}: dec_ctrl = CTRL_XOR;
               {F7_BASE, 3'b001}: dec_ctrl = CTRL_SLL;
               default: begin
                  dec_ctrl    = CTRL_ILL;
                  dec_illegal = 1'b1;
               end
            endcase
         end
         default: begin
            // I-type ALU: funct7 only matters for the arithmetic shift
            if (funct3_i == 3'b000) begin
               dec_ctrl    = CTRL_ADD;
               dec_illegal = 1'b0;
            end else if (funct3_i == 3'b101 && funct7_i == F7_ALT) begin
               dec_ctrl    = CTRL_SRA;
               dec_illegal = 1'b0;
            end
         end
      endcase
   end

   // Choose the next stage contents: flush over stall over normal capture.
   always_comb begin
      data1_next    = data1_reg;
      data2_next    = data2_reg;
      ctrl_next     = ctrl_reg;
      rd_next       = rd_reg;
      regwrite_next = regwrite_reg;
      valid_next    = valid_reg;
      illegal_next  = illegal_reg;
      if (flush_i) begin
         data1_next    = '0;
         data2_next    = '0;
         ctrl_next     = CTRL_ADD;
         rd_next       = '0;
         regwrite_next = 1'b0;
         valid_next    = 1'b0;
         illegal_next  = 1'b0;
      end else if (!stall_i) begin
         // operands are captured even for a bubble so downstream sees real data
         data1_next = RS1data_i;
         data2_next = ALUSrc_i ? imm_i : RS2data_i;
         if (valid_i) begin
            ctrl_next     = dec_ctrl;
            rd_next       = RDaddr_i;
            regwrite_next = RegWrite_i & ~dec_illegal;
            valid_next    = 1'b1;
            illegal_next  = dec_illegal;
         end else begin
            ctrl_next     = CTRL_ADD;
            rd_next       = '0;
            regwrite_next = 1'b0;
            valid_next    = 1'b0;
            illegal_next  = 1'b0;
         end
      end
   end

   // Stage register; reset overrides flush and stall.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data1_reg    <= '0;
         data2_reg    <= '0;
         ctrl_reg     <= CTRL_ADD;
         rd_reg       <= '0;
         regwrite_reg <= 1'b0;
         valid_reg    <= 1'b0;
         illegal_reg  <= 1'b0;
      end else begin
         data1_reg    <= data1_next;
         data2_reg    <= data2_next;
         ctrl_reg     <= ctrl_next;
         rd_reg       <= rd_next;
         regwrite_reg <= regwrite_next;
         valid_reg    <= valid_next;
         illegal_reg  <= illegal_next;
      end
   end

   assign data1_o    = data1_reg;
   assign data2_o    = data2_reg;
   assign ALUCtrl_o  = ctrl_reg;
   assign RDaddr_o   = rd_reg;
   assign RegWrite_o = regwrite_reg;
   assign valid_o    = valid_reg;
   assign illegal_o  = illegal_reg;

endmodule

// File: tb/tb_id_ex_alu_stage.sv
// Scoreboard bench for id_ex_alu_stage: the driver predicts each cycle's
// stage contents from a reference model and queues them; the monitor pops one
// entry after every rising edge and compares it with the DUT outputs.
module tb_id_ex_alu_stage;

   localparam int WIDTH = 32;

   typedef struct packed {
      logic [WIDTH-1:0] d1;
      logic [WIDTH-1:0] d2;
      logic [3:0]       ctrl;
      logic [4:0]       rd;
      logic             rw;
      logic             v;
      logic             ill;
   } stage_t;

   logic             clk = 1'b0;
   logic             rst_i, valid_i, ALUSrc_i, RegWrite_i, stall_i, flush_i;
   logic [1:0]       ALUOp_i;
   logic [6:0]       funct7_i;
   logic [2:0]       funct3_i;
   logic [WIDTH-1:0] RS1data_i, RS2data_i, imm_i;
   logic [4:0]       RDaddr_i;
   logic [WIDTH-1:0] data1_o, data2_o;
   logic [3:0]       ALUCtrl_o;
   logic [4:0]       RDaddr_o;
   logic             RegWrite_o, valid_o, illegal_o;

   stage_t model;
   stage_t exp_q[$];
   int     vec_cnt  = 0;
   int     miss_cnt = 0;
   int     cyc      = 0;

   always #5 clk = ~clk;

   id_ex_alu_stage #(.WIDTH(WIDTH)) dut (
      .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ALUOp_i(ALUOp_i),
      .funct7_i(funct7_i), .funct3_i(funct3_i), .ALUSrc_i(ALUSrc_i),
      .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .imm_i(imm_i),
      .RDaddr_i(RDaddr_i), .RegWrite_i(RegWrite_i), .stall_i(stall_i),
      .flush_i(flush_i), .data1_o(data1_o), .data2_o(data2_o),
      .ALUCtrl_o(ALUCtrl_o), .RDaddr_o(RDaddr_o), .RegWrite_o(RegWrite_o),
      .valid_o(valid_o), .illegal_o(illegal_o)
   );

   // Reference decode: returns {illegal, ctrl} from the instruction table.
   function automatic logic [4:0] ref_decode(logic [1:0] op, logic [6:0] f7, logic [2:0] f3);
      logic [13:0] rtab [6];
      rtab[0] = {7'h00, 3'd0, 4'b0010};
      rtab[1] = {7'h20, 3'd0, 4'b0110};
      rtab[2] = {7'h01, 3'd0, 4'b1001};
      rtab[3] = {7'h00, 3'd7, 4'b0000};
      rtab[4] = {7'h00, 3'd4, 4'b0001};
      rtab[5] = {7'h00, 3'd1, 4'b1000};
      if (op == 2'd0) return {1'b0, 4'b0010};
      if (op == 2'd1) return {1'b0, 4'b0110};
      if (op == 2'd2) begin
         for (int i = 0; i < 6; i++)
            if (rtab[i][13:4] == {f7, f3}) return {1'b0, rtab[i][3:0]};
         return {1'b1, 4'b1111};
      end
      if (f3 == 3'd0) return {1'b0, 4'b0010};
      if (f3 == 3'd5 && f7 == 7'h20) return {1'b0, 4'b1010};
      return {1'b1, 4'b1111};
   endfunction

   // Drive one cycle of inputs at the falling edge and queue the predicted result.
   task automatic drive(input logic rst, input logic flush, input logic stall,
                        input logic valid, input logic [1:0] op, input logic [6:0] f7,
                        input logic [2:0] f3, input logic src, input logic [WIDTH-1:0] rs1,
                        input logic [WIDTH-1:0] rs2, input logic [WIDTH-1:0] imm,
                        input logic [4:0] rd, input logic rw);
      logic [4:0] dec;
      @(negedge clk);
      rst_i = rst; flush_i = flush; stall_i = stall; valid_i = valid;
      ALUOp_i = op; funct7_i = f7; funct3_i = f3; ALUSrc_i = src;
      RS1data_i = rs1; RS2data_i = rs2; imm_i = imm; RDaddr_i = rd; RegWrite_i = rw;
      if (rst || flush) begin
         model = '{d1: '0, d2: '0, ctrl: 4'b0010, rd: '0, rw: 1'b0, v: 1'b0, ill: 1'b0};
      end else if (!stall) begin
         model.d1 = rs1;
         model.d2 = src ? imm : rs2;
         if (valid) begin
            dec = ref_decode(op, f7, f3);
            model.ctrl = dec[3:0];
            model.ill  = dec[4];
            model.rd   = rd;
            model.v    = 1'b1;
            model.rw   = rw && !dec[4];
         end else begin
            model.ctrl = 4'b0010;
            model.ill  = 1'b0;
            model.rd   = '0;
            model.v    = 1'b0;
            model.rw   = 1'b0;
         end
      end
      exp_q.push_back(model);
   endtask

   // Convenience wrapper for a plain valid instruction.
   task automatic instr(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                        input logic src, input logic [WIDTH-1:0] rs1,
                        input logic [WIDTH-1:0] rs2, input logic [WIDTH-1:0] imm,
                        input logic [4:0] rd);
      drive(1'b0, 1'b0, 1'b0, 1'b1, op, f7, f3, src, rs1, rs2, imm, rd, 1'b1);
   endtask

   // Random inputs with selectable control flags.
   task automatic rand_cycle(input logic rst, input logic flush, input logic stall);
      logic [6:0] f7;
      case ($urandom_range(0, 3))
         0: f7 = 7'h00;
         1: f7 = 7'h20;
         2: f7 = 7'h01;
         default: f7 = 7'($urandom);
      endcase
      drive(rst, flush, stall, $urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), f7,
            3'($urandom_range(0, 7)), 1'($urandom), $urandom, $urandom, $urandom,
            5'($urandom), 1'($urandom));
   endtask

   // Monitor: after each rising edge, compare DUT outputs with the oldest prediction.
   initial begin
      stage_t e, a;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{d1: data1_o, d2: data2_o, ctrl: ALUCtrl_o, rd: RDaddr_o,
                  rw: RegWrite_o, v: valid_o, ill: illegal_o};
            vec_cnt++;
            if (a !== e) begin
               miss_cnt++;
               $display("FAIL stage cyc=%0d got d1=%h d2=%h ctrl=%b rd=%0d rw=%b v=%b ill=%b want d1=%h d2=%h ctrl=%b rd=%0d rw=%b v=%b ill=%b",
                        cyc, a.d1, a.d2, a.ctrl, a.rd, a.rw, a.v, a.ill,
                        e.d1, e.d2, e.ctrl, e.rd, e.rw, e.v, e.ill);
            end else begin
               $display("ok cyc=%0d ctrl=%b d1=%h d2=%h rd=%0d rw=%b v=%b ill=%b",
                        cyc, a.ctrl, a.d1, a.d2, a.rd, a.rw, a.v, a.ill);
            end
         end
      end
   end

   // Stimulus: directed scenarios, then randomized traffic.
   initial begin
      model = '0;
      rst_i = 1'b1; flush_i = 1'b0; stall_i = 1'b0; valid_i = 1'b0;
      ALUOp_i = '0; funct7_i = '0; funct3_i = '0; ALUSrc_i = 1'b0;
      RS1data_i = '0; RS2data_i = '0; imm_i = '0; RDaddr_i = '0; RegWrite_i = 1'b0;

      // reset, including with flush/stall asserted
      drive(1, 0, 0, 1, 2'd2, 7'h00, 3'd0, 0, 32'h11, 32'h22, 32'h0, 5'd3, 1);
      drive(1, 1, 1, 1, 2'd2, 7'h00, 3'd0, 0, 32'h11, 32'h22, 32'h0, 5'd3, 1);

      // R-type sub
      instr(2'd2, 7'h20, 3'd0, 0, 32'd7, 32'd3, 32'd99, 5'd5);
      // srai, then the same with wrong funct7 (illegal)
      instr(2'd3, 7'h20, 3'd5, 1, 32'hFFFF_FF00, 32'd8, 32'd4, 5'd6);
      instr(2'd3, 7'h00, 3'd5, 1, 32'hFFFF_FF00, 32'd8, 32'd4, 5'd6);
      // invalid instruction with illegal decode: bubble but data captured
      drive(0, 0, 0, 0, 2'd2, 7'h7F, 3'd3, 0, 32'hA5A5, 32'h5A5A, 32'd1, 5'd7, 1);
      // remaining legal R-type codes, load/store and branch
      instr(2'd2, 7'h00, 3'd7, 0, 32'd1, 32'd2, 32'd0, 5'd8);
      instr(2'd2, 7'h00, 3'd1, 0, 32'd3, 32'd4, 32'd0, 5'd9);
      instr(2'd0, 7'h55, 3'd2, 1, 32'd5, 32'd6, 32'd16, 5'd10);
      instr(2'd1, 7'h00, 3'd0, 0, 32'd5, 32'd6, 32'd16, 5'd0);

      // mul then a 3-cycle stall with changing inputs, then release
      instr(2'd2, 7'h01, 3'd0, 0, 32'd12, 32'd13, 32'd0, 5'd11);
      for (int i = 0; i < 3; i++) rand_cycle(0, 0, 1);
      instr(2'd2, 7'h00, 3'd0, 0, 32'd20, 32'd21, 32'd0, 5'd12);

      // flush together with stall while holding a valid add
      instr(2'd2, 7'h00, 3'd0, 0, 32'd30, 32'd31, 32'd0, 5'd13);
      drive(0, 0, 1, 1, 2'd2, 7'h00, 3'd0, 0, 32'd1, 32'd1, 32'd0, 5'd1, 1);
      drive(0, 1, 1, 1, 2'd2, 7'h00, 3'd0, 0, 32'd2, 32'd2, 32'd0, 5'd2, 1);

      // reset during a stall holding RD=9, then a valid xor
      instr(2'd0, 7'h00, 3'd0, 1, 32'd40, 32'd41, 32'd8, 5'd9);
      drive(0, 0, 1, 1, 2'd2, 7'h01, 3'd0, 0, 32'd1, 32'd1, 32'd0, 5'd1, 1);
      drive(1, 0, 1, 1, 2'd2, 7'h01, 3'd0, 0, 32'd1, 32'd1, 32'd0, 5'd1, 1);
      instr(2'd2, 7'h00, 3'd4, 0, 32'hF0, 32'h0F, 32'd0, 5'd14);

      // randomized traffic
      for (int i = 0; i < 300; i++)
         rand_cycle($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 5) == 0);

      // drain the scoreboard with a bounded wait
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
         vec_cnt++;
         miss_cnt++;
         $display("FAIL drain got %0d pending entries want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
